float_mul_pipe: RTL

- Pipelined, handshaked floating-point multiplier; upstream of the combinational float adder in the CNN datapath.
- Each product it emits is one adder operand in the convolution multiply-accumulate chain.
- Number conventions match the adder: IEEE-style sign/exponent/mantissa layout, truncation rounding, no NaN/Inf/denormal semantics.
- Three register stages, valid/ready on both sides, a `last` flag carried alongside each product.

---
 rtl/float_mul_pipe.sv | 123 ++++++++++++
 1 files changed

// File: rtl/float_mul_pipe.sv
// Three-stage pipelined floating-point multiplier with valid/ready handshakes on both sides.
// Truncating, with zero/underflow flushed to +0 and overflow clamped to a signed all-ones exponent.
module float_mul_pipe #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] A,
  input  logic [DATA_WIDTH-1:0] B,
  input  logic                  in_last,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] C,
  output logic                  out_last
);

  localparam int EW   = (DATA_WIDTH == 16) ? 5  : (DATA_WIDTH == 64) ? 11 : 8;
  localparam int MW   = (DATA_WIDTH == 16) ? 10 : (DATA_WIDTH == 64) ? 52 : 23;
  localparam int BIAS = (1 << (EW - 1)) - 1;
  localparam int EXW  = EW + 2;
  localparam int PW   = 2 * (MW + 1);
  localparam int EMAX = (1 << EW) - 1;

  function automatic logic signed [EXW-1:0] exp_sum(input logic [EW-1:0] ea,
                                                    input logic [EW-1:0] eb);
    return $signed({2'b00, ea}) + $signed({2'b00, eb}) - $signed(EXW'(BIAS));
  endfunction

  // Normalize by at most one position, truncate, then flush or clamp the exponent.
  function automatic logic [DATA_WIDTH-1:0] pack(input logic                  zero,
                                                 input logic                  sign,
                                                 input logic signed [EXW-1:0] e,
                                                 input logic [PW-1:0]         p);
    int            ei;
    logic [MW-1:0] mant;
    ei = int'(e);
    if (p[PW-1]) begin
      mant = MW'(p >> (MW + 1));
      ei   = ei + 1;
    end else begin
      mant = MW'(p >> MW);
    end
    if (zero)
      return '0;
    if (ei <= 0)
      return '0;
    if (ei >= EMAX)
      return DATA_WIDTH'({sign, {EW{1'b1}}, {MW{1'b0}}});
    return DATA_WIDTH'({sign, EW'(ei), mant});
  endfunction

  logic                  advance;

  logic                  vld_p0;
  logic                  zero_p0;
  logic                  sign_p0;
  logic                  last_p0;
  logic signed [EXW-1:0] exp_p0;
  logic [MW:0]           fa_p0;
  logic [MW:0]           fb_p0;

  logic                  vld_p1;
  logic                  zero_p1;
  logic                  sign_p1;
  logic                  last_p1;
  logic signed [EXW-1:0] exp_p1;
  logic [PW-1:0]         prod_p1;

  logic                  vld_p2;
  logic                  last_p2;
  logic [DATA_WIDTH-1:0] c_p2;

  // The whole pipe moves as one; bubbles travel with their valid bits.
  assign advance   = !vld_p2 || out_ready;
  assign in_ready  = advance;
  assign out_valid = vld_p2;
  assign C         = c_p2;
  assign out_last  = last_p2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p0  <= 1'b0;
      zero_p0 <= 1'b0;
      sign_p0 <= 1'b0;
      last_p0 <= 1'b0;
      exp_p0  <= '0;
      fa_p0   <= '0;
      fb_p0   <= '0;
      vld_p1  <= 1'b0;
      zero_p1 <= 1'b0;
      sign_p1 <= 1'b0;
      last_p1 <= 1'b0;
      exp_p1  <= '0;
      prod_p1 <= '0;
      vld_p2  <= 1'b0;
      last_p2 <= 1'b0;
      c_p2    <= '0;
    end else if (advance) begin
      // S1: decode operands
      vld_p0  <= in_valid;
      zero_p0 <= (A[DATA_WIDTH-2:0] == '0) || (B[DATA_WIDTH-2:0] == '0);
      sign_p0 <= A[DATA_WIDTH-1] ^ B[DATA_WIDTH-1];
      last_p0 <= in_last;
      exp_p0  <= exp_sum(A[DATA_WIDTH-2 -: EW], B[DATA_WIDTH-2 -: EW]);
      fa_p0   <= {1'b1, A[MW-1:0]};
      fb_p0   <= {1'b1, B[MW-1:0]};
      // S2: significand multiply
      vld_p1  <= vld_p0;
      zero_p1 <= zero_p0;
      sign_p1 <= sign_p0;
      last_p1 <= last_p0;
      exp_p1  <= exp_p0;
      prod_p1 <= PW'(fa_p0) * PW'(fb_p0);
      // S3: normalize and pack
      vld_p2  <= vld_p1;
      last_p2 <= last_p1;
      c_p2    <= pack(zero_p1, sign_p1, exp_p1, prod_p1);
    end
  end

endmodule
